// File: rtl/panel_blend_if.sv
// Pixel channels of the panel blend stage: background and foreground inputs,
// global brightness, and the composited output, each with its valid/ack pair.
interface panel_blend_if;
    logic       bg_valid;
    logic [7:0] bg_red;
    logic [7:0] bg_green;
    logic [7:0] bg_blue;
    logic       bg_ack;

    logic       fg_valid;
    logic [7:0] fg_red;
    logic [7:0] fg_green;
    logic [7:0] fg_blue;
    logic [7:0] fg_alpha;
    logic       fg_ack;

    logic [7:0] bright;

    logic       out_valid;
    logic [7:0] out_red;
    logic [7:0] out_green;
    logic [7:0] out_blue;
    logic       out_ack;

    // Master is the surrounding pipeline (producers and consumer).
    modport master (
        output bg_valid, bg_red, bg_green, bg_blue,
        output fg_valid, fg_red, fg_green, fg_blue, fg_alpha,
        output bright, out_ack,
        input  bg_ack, fg_ack, out_valid, out_red, out_green, out_blue
    );

    modport slave (
        input  bg_valid, bg_red, bg_green, bg_blue,
        input  fg_valid, fg_red, fg_green, fg_blue, fg_alpha,
        input  bright, out_ack,
        output bg_ack, fg_ack, out_valid, out_red, out_green, out_blue
    );
endinterface

// File: rtl/panel_blend.sv
// Alpha-composites a foreground RGBA pixel over a background RGB pixel, then
// applies global brightness; one pixel in flight, four-state pipeline.
module panel_blend #(
    parameter bit USE_BRIGHT = 1'b1,
    parameter bit ROUND      = 1'b1
) (
    input logic          clk,
    input logic          reset_n,
    panel_blend_if.slave bus
);

    typedef enum logic [1:0] {COLLECT, MUL, SCALE, HOLD} state_t;

    // Divide by 255; the rounding form is exact for multiples of 255 and needs 17 bits.
    function automatic logic [7:0] div255(input logic [15:0] sum);
        logic [16:0] t;
        logic [16:0] q;
        if (ROUND) begin
            t = {1'b0, sum} + 17'd128;
            q = t + (t >> 8);
            return 8'(q >> 8);
        end
        return 8'(sum >> 8);
    endfunction

    function automatic logic [7:0] mix(input logic [7:0] f, input logic [7:0] b,
                                       input logic [7:0] a);
        logic [15:0] s;
        s = 16'(f) * 16'(a) + 16'(b) * 16'(8'd255 - a);
        return div255(s);
    endfunction

    state_t     state_q, state_d;
    logic       bg_flag_q, bg_flag_d, fg_flag_q, fg_flag_d;
    logic       bg_ack_q, bg_ack_d, fg_ack_q, fg_ack_d;
    logic [7:0] bg_red_q, bg_red_d, bg_green_q, bg_green_d, bg_blue_q, bg_blue_d;
    logic [7:0] fg_red_q, fg_red_d, fg_green_q, fg_green_d, fg_blue_q, fg_blue_d;
    logic [7:0] fg_alpha_q, fg_alpha_d;
    logic [7:0] blend_red_q, blend_red_d, blend_green_q, blend_green_d;
    logic [7:0] blend_blue_q, blend_blue_d;
    logic [7:0] out_red_q, out_red_d, out_green_q, out_green_d, out_blue_q, out_blue_d;
    logic       out_valid_q, out_valid_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= COLLECT;
            bg_flag_q     <= 1'b0;
            fg_flag_q     <= 1'b0;
            bg_ack_q      <= 1'b0;
            fg_ack_q      <= 1'b0;
            bg_red_q      <= '0;
            bg_green_q    <= '0;
            bg_blue_q     <= '0;
            fg_red_q      <= '0;
            fg_green_q    <= '0;
            fg_blue_q     <= '0;
            fg_alpha_q    <= '0;
            blend_red_q   <= '0;
            blend_green_q <= '0;
            blend_blue_q  <= '0;
            out_red_q     <= '0;
            out_green_q   <= '0;
            out_blue_q    <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bg_flag_q     <= bg_flag_d;
            fg_flag_q     <= fg_flag_d;
            bg_ack_q      <= bg_ack_d;
            fg_ack_q      <= fg_ack_d;
            bg_red_q      <= bg_red_d;
            bg_green_q    <= bg_green_d;
            bg_blue_q     <= bg_blue_d;
            fg_red_q      <= fg_red_d;
            fg_green_q    <= fg_green_d;
            fg_blue_q     <= fg_blue_d;
            fg_alpha_q    <= fg_alpha_d;
            blend_red_q   <= blend_red_d;
            blend_green_q <= blend_green_d;
            blend_blue_q  <= blend_blue_d;
            out_red_q     <= out_red_d;
            out_green_q   <= out_green_d;
            out_blue_q    <= out_blue_d;
            out_valid_q   <= out_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bg_flag_d     = bg_flag_q;
        fg_flag_d     = fg_flag_q;
        bg_ack_d      = 1'b0;
        fg_ack_d      = 1'b0;
        bg_red_d      = bg_red_q;
        bg_green_d    = bg_green_q;
        bg_blue_d     = bg_blue_q;
        fg_red_d      = fg_red_q;
        fg_green_d    = fg_green_q;
        fg_blue_d     = fg_blue_q;
        fg_alpha_d    = fg_alpha_q;
        blend_red_d   = blend_red_q;
        blend_green_d = blend_green_q;
        blend_blue_d  = blend_blue_q;
        out_red_d     = out_red_q;
        out_green_d   = out_green_q;
        out_blue_d    = out_blue_q;
        out_valid_d   = out_valid_q;

        unique case (state_q)
            COLLECT: begin
                // The ack cycle masks the producer's stale valid.
                if (!bg_flag_q && bus.bg_valid && !bg_ack_q) begin
                    bg_red_d   = bus.bg_red;
                    bg_green_d = bus.bg_green;
                    bg_blue_d  = bus.bg_blue;
                    bg_flag_d  = 1'b1;
                    bg_ack_d   = 1'b1;
                end
                if (!fg_flag_q && bus.fg_valid && !fg_ack_q) begin
                    fg_red_d   = bus.fg_red;
                    fg_green_d = bus.fg_green;
                    fg_blue_d  = bus.fg_blue;
                    fg_alpha_d = bus.fg_alpha;
                    fg_flag_d  = 1'b1;
                    fg_ack_d   = 1'b1;
                end
                if (bg_flag_q && fg_flag_q) begin
                    state_d = MUL;
                end
            end
            MUL: begin
                blend_red_d   = mix(fg_red_q, bg_red_q, fg_alpha_q);
                blend_green_d = mix(fg_green_q, bg_green_q, fg_alpha_q);
                blend_blue_d  = mix(fg_blue_q, bg_blue_q, fg_alpha_q);
                state_d       = SCALE;
            end
            SCALE: begin
                if (USE_BRIGHT) begin
                    out_red_d   = div255(16'(blend_red_q) * 16'(bus.bright));
                    out_green_d = div255(16'(blend_green_q) * 16'(bus.bright));
                    out_blue_d  = div255(16'(blend_blue_q) * 16'(bus.bright));
                end else begin
                    out_red_d   = blend_red_q;
                    out_green_d = blend_green_q;
                    out_blue_d  = blend_blue_q;
                end
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.out_ack) begin
                    out_valid_d = 1'b0;
                    bg_flag_d   = 1'b0;
                    fg_flag_d   = 1'b0;
                    state_d     = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign bus.bg_ack    = bg_ack_q;
    assign bus.fg_ack    = fg_ack_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_red   = out_red_q;
    assign bus.out_green = out_green_q;
    assign bus.out_blue  = out_blue_q;

endmodule

// File: tb/tb_panel_blend.sv
// Self-checking bench for panel_blend: vector table with hand-computed results,
// a queue scoreboard, and sequences for skew, back-pressure and mid-flight reset.
module tb_panel_blend;

    typedef struct {
        logic [7:0] bgR, bgG, bgB;
        logic [7:0] fgR, fgG, fgB, fgA;
        logic [7:0] bright;
        logic [7:0] expR, expG, expB;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    panel_blend_if bus();

    panel_blend #(.USE_BRIGHT(1'b1), .ROUND(1'b1)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cycle = 0;
    int bgAcks = 0;
    int fgAcks = 0;
    int lastAck = 0;
    int riseCyc = 0;
    bit prevOv = 1'b0;
    logic [23:0] expQ[$];
    vec_t vecs[7];

    // Cycle counter and ack/out_valid edge bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        cycle++;
        if (bus.bg_ack === 1'b1) begin
            bgAcks++;
            lastAck = cycle;
        end
        if (bus.fg_ack === 1'b1) begin
            fgAcks++;
            lastAck = cycle;
        end
        if (bus.out_valid === 1'b1 && !prevOv) riseCyc = cycle;
        prevOv = (bus.out_valid === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic produce(input bit isBg, input int skew, input vec_t v);
        int n;
        repeat (skew) begin
            @(posedge clk);
            #1;
        end
        if (isBg) begin
            bus.bg_red   = v.bgR;
            bus.bg_green = v.bgG;
            bus.bg_blue  = v.bgB;
            bus.bg_valid = 1'b1;
        end else begin
            bus.fg_red   = v.fgR;
            bus.fg_green = v.fgG;
            bus.fg_blue  = v.fgB;
            bus.fg_alpha = v.fgA;
            bus.fg_valid = 1'b1;
        end
        n = 0;
        while (!(isBg ? bus.bg_ack : bus.fg_ack) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(isBg ? "bg_ack_seen" : "fg_ack_seen", {31'd0, (isBg ? bus.bg_ack : bus.fg_ack)}, 1);
        @(posedge clk);
        #1;
        if (isBg) bus.bg_valid = 1'b0;
        else bus.fg_valid = 1'b0;
    endtask

    task automatic consume(input int ackDelay, input string tag);
        int n;
        logic [23:0] exp;
        bit stable;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        exp = (expQ.size() > 0) ? expQ.pop_front() : 24'd0;
        check({tag, " out_valid"}, {31'd0, bus.out_valid}, 1);
        if (bus.out_valid !== 1'b1) return;
        @(negedge clk);
        #1;
        check({tag, " latency"}, riseCyc - lastAck, 3);
        check({tag, " pixel"}, {8'd0, bus.out_red, bus.out_green, bus.out_blue}, {8'd0, exp});
        stable = 1'b1;
        repeat (ackDelay) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b1 || {bus.out_red, bus.out_green, bus.out_blue} !== exp)
                stable = 1'b0;
        end
        if (ackDelay > 0) check({tag, " held"}, {31'd0, stable}, 1);
        bus.out_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ack = 1'b0;
        check({tag, " out_valid_fall"}, {31'd0, bus.out_valid}, 0);
    endtask

    task automatic runVector(input vec_t v, input int fgSkew, input int bgSkew,
                             input int ackDelay, input string tag);
        int b0, f0;
        b0 = bgAcks;
        f0 = fgAcks;
        bus.bright = v.bright;
        expQ.push_back({v.expR, v.expG, v.expB});
        fork
            produce(1'b1, bgSkew, v);
            produce(1'b0, fgSkew, v);
        join
        consume(ackDelay, tag);
        check({tag, " bg_ack count"}, bgAcks - b0, 1);
        check({tag, " fg_ack count"}, fgAcks - f0, 1);
    endtask

    task automatic waitOutValid(input string tag);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " out_valid"}, {31'd0, bus.out_valid}, 1);
    endtask

    task automatic checkOutputsZero(input string tag);
        check({tag, " out_valid"}, {31'd0, bus.out_valid}, 0);
        check({tag, " out_pixel"}, {8'd0, bus.out_red, bus.out_green, bus.out_blue}, 0);
    endtask

    initial begin
        int b0, f0;
        vecs[0] = '{8'd10, 8'd20, 8'd30, 8'd200, 8'd100, 8'd50, 8'd255, 8'd255,
                    8'd200, 8'd100, 8'd50};
        vecs[1] = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd128, 8'd255,
                    8'd128, 8'd0, 8'd127};
        vecs[2] = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd128, 8'd128,
                    8'd64, 8'd0, 8'd64};
        vecs[3] = '{8'd11, 8'd22, 8'd33, 8'd99, 8'd99, 8'd99, 8'd0, 8'd255,
                    8'd11, 8'd22, 8'd33};
        vecs[4] = '{8'd100, 8'd150, 8'd200, 8'd50, 8'd60, 8'd70, 8'd200, 8'd0,
                    8'd0, 8'd0, 8'd0};
        vecs[5] = '{8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd64, 8'd255,
                    8'd191, 8'd191, 8'd191};
        vecs[6] = '{8'd40, 8'd80, 8'd120, 8'd200, 8'd160, 8'd120, 8'd100, 8'd200,
                    8'd81, 8'd87, 8'd94};

        bus.bg_valid = 1'b0;
        bus.bg_red   = '0;
        bus.bg_green = '0;
        bus.bg_blue  = '0;
        bus.fg_valid = 1'b0;
        bus.fg_red   = '0;
        bus.fg_green = '0;
        bus.fg_blue  = '0;
        bus.fg_alpha = '0;
        bus.bright   = 8'd255;
        bus.out_ack  = 1'b0;
        reset_n      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutputsZero("reset");
        check("reset bg_ack", {31'd0, bus.bg_ack}, 0);
        check("reset fg_ack", {31'd0, bus.fg_ack}, 0);
        reset_n = 1'b1;

        // Idle with a stray out_ack, which must be ignored outside HOLD.
        bus.out_ack = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        bus.out_ack = 1'b0;
        check("idle ack pulses", bgAcks + fgAcks, 0);
        checkOutputsZero("idle");

        for (int i = 0; i < 7; i++) begin
            runVector(vecs[i], 0, 0, i % 3, $sformatf("vec%0d", i));
        end

        runVector(vecs[6], 0, 5, 0, "skew_fg_first");
        runVector(vecs[1], 3, 0, 1, "skew_bg_first");

        // Back-pressure: next pair offered while the current pixel waits in HOLD.
        bus.bright = vecs[0].bright;
        expQ.push_back({vecs[0].expR, vecs[0].expG, vecs[0].expB});
        fork
            produce(1'b1, 0, vecs[0]);
            produce(1'b0, 0, vecs[0]);
        join
        waitOutValid("bp wait");
        b0 = bgAcks;
        f0 = fgAcks;
        bus.bright = vecs[6].bright;
        expQ.push_back({vecs[6].expR, vecs[6].expG, vecs[6].expB});
        fork
            produce(1'b1, 0, vecs[6]);
            produce(1'b0, 0, vecs[6]);
        join_none
        consume(10, "bp_first");
        check("bp no ack during hold", (bgAcks - b0) + (fgAcks - f0), 0);
        wait fork;
        consume(0, "bp_second");
        check("bp bg_ack count", bgAcks - b0, 1);
        check("bp fg_ack count", fgAcks - f0, 1);

        // Reset while the pixel sits in SCALE: nothing may come out.
        bus.bright = 8'd255;
        fork
            produce(1'b1, 0, vecs[1]);
            produce(1'b0, 0, vecs[1]);
        join
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutputsZero("rst_scale now");
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutputsZero("rst_scale after");
        runVector(vecs[2], 0, 0, 0, "post_rst_scale");

        // Reset while a valid pixel is held: outputs drop without a clock edge.
        bus.bright = vecs[0].bright;
        fork
            produce(1'b1, 0, vecs[0]);
            produce(1'b0, 0, vecs[0]);
        join
        waitOutValid("rst_hold wait");
        check("rst_hold pixel", {8'd0, bus.out_red, bus.out_green, bus.out_blue},
              {8'd0, vecs[0].expR, vecs[0].expG, vecs[0].expB});
        #1;
        reset_n = 1'b0;
        #1;
        checkOutputsZero("rst_hold now");
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1;
        runVector(vecs[3], 0, 0, 0, "post_rst_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
